// File: rtl/runahead_controller_if.sv
// Core-side bundle for the runahead controller: miss/refill/decode inputs and
// the decoder, register-file, fetch and hazard-facing outputs.
interface runahead_controller_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  ra_enable;
    logic                  mem_load_miss;
    logic [ADDR_WIDTH-1:0] mem_load_pc;
    logic                  mem_miss_done;
    logic                  dec_load;
    logic                  runahead_mode;
    logic                  stall_release;
    logic                  checkpoint_save;
    logic                  checkpoint_restore;
    logic                  pipeline_flush;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [CNT_WIDTH-1:0]  ra_entries;
    logic [CNT_WIDTH-1:0]  ra_loads;

    modport master (
        output ra_enable, mem_load_miss, mem_load_pc, mem_miss_done, dec_load,
        input  runahead_mode, stall_release, checkpoint_save, checkpoint_restore,
               pipeline_flush, redirect_valid, redirect_pc, ra_entries, ra_loads
    );

    modport slave (
        input  ra_enable, mem_load_miss, mem_load_pc, mem_miss_done, dec_load,
        output runahead_mode, stall_release, checkpoint_save, checkpoint_restore,
               pipeline_flush, redirect_valid, redirect_pc, ra_entries, ra_loads
    );
endinterface

// File: rtl/runahead_controller.sv
// Runahead sequencer: checkpoints on a D-cache load miss, pre-executes while the
// refill is outstanding, then flushes, restores and redirects fetch to the load.
module runahead_controller #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned MAX_RA_CYCLES = 256,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    runahead_controller_if.slave bus
);
    localparam int unsigned    TW     = (MAX_RA_CYCLES > 1) ? $clog2(MAX_RA_CYCLES) : 1;
    localparam logic [TW-1:0]  T_LAST = TW'(MAX_RA_CYCLES - 1);

    typedef enum logic [2:0] {NORMAL, ENTER, RUNAHEAD, EXIT, WAIT} state_t;

    state_t                state;
    state_t                state_next;
    logic [TW-1:0]         ra_cnt;
    logic                  done_seen;
    logic [ADDR_WIDTH-1:0] ckpt_pc;
    logic [CNT_WIDTH-1:0]  entries_q;
    logic [CNT_WIDTH-1:0]  loads_q;
    logic                  mode_q;
    logic                  stall_q;
    logic                  save_q;
    logic                  restore_q;
    logic                  flush_q;
    logic                  rvalid_q;

    always_comb begin
        state_next = state;
        case (state)
            NORMAL:   if (bus.ra_enable && bus.mem_load_miss && !bus.mem_miss_done)
                          state_next = ENTER;
            ENTER:    state_next = RUNAHEAD;
            RUNAHEAD: if (bus.mem_miss_done || done_seen || (ra_cnt == T_LAST) || !bus.ra_enable)
                          state_next = EXIT;
            EXIT:     state_next = (done_seen || bus.mem_miss_done) ? NORMAL : WAIT;
            WAIT:     if (bus.mem_miss_done) state_next = NORMAL;
            default:  state_next = NORMAL;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= NORMAL;
            ra_cnt    <= '0;
            done_seen <= 1'b0;
            ckpt_pc   <= '0;
            entries_q <= '0;
            loads_q   <= '0;
            mode_q    <= 1'b0;
            stall_q   <= 1'b0;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            flush_q   <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                NORMAL: begin
                    if (state_next == ENTER) begin
                        ckpt_pc   <= bus.mem_load_pc;
                        entries_q <= entries_q + CNT_WIDTH'(1);
                        done_seen <= 1'b0;
                    end
                end
                ENTER: begin
                    ra_cnt <= '0;
                    if (bus.mem_miss_done) done_seen <= 1'b1;
                end
                RUNAHEAD: begin
                    ra_cnt <= ra_cnt + TW'(1);
                    if (bus.dec_load)      loads_q   <= loads_q + CNT_WIDTH'(1);
                    if (bus.mem_miss_done) done_seen <= 1'b1;
                end
                EXIT: begin
                    if (bus.mem_miss_done) done_seen <= 1'b1;
                end
                default: ;
            endcase
            mode_q    <= (state_next == ENTER) || (state_next == RUNAHEAD) || (state_next == EXIT);
            stall_q   <= (state_next == RUNAHEAD);
            save_q    <= (state_next == ENTER);
            restore_q <= (state_next == EXIT);
            flush_q   <= (state_next == EXIT);
            rvalid_q  <= (state_next == EXIT);
        end
    end

    assign bus.runahead_mode      = mode_q;
    assign bus.stall_release      = stall_q;
    assign bus.checkpoint_save    = save_q;
    assign bus.checkpoint_restore = restore_q;
    assign bus.pipeline_flush     = flush_q;
    assign bus.redirect_valid     = rvalid_q;
    assign bus.redirect_pc        = ckpt_pc;
    assign bus.ra_entries         = entries_q;
    assign bus.ra_loads           = loads_q;
endmodule

// File: tb/tb_runahead_controller.sv
// Scoreboarded directed bench: per-cycle expected outputs are queued by the
// stimulus process and checked by an independent monitor on the falling edge.
module tb_runahead_controller;
    localparam int P_N = 0, P_E = 1, P_R = 2, P_X = 3, P_W = 4;
    localparam int NV  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    runahead_controller_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bus_a ();
    runahead_controller_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bus_b ();

    runahead_controller #(.ADDR_WIDTH(32), .MAX_RA_CYCLES(256), .CNT_WIDTH(16))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    runahead_controller #(.ADDR_WIDTH(32), .MAX_RA_CYCLES(8), .CNT_WIDTH(16))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    typedef struct {
        int          test;
        int          cyc;
        bit          use_b;
        logic [5:0]  flags;
        bit          chk_pc;
        logic [31:0] pc;
        bit          chk_cnt;
        logic [15:0] ent;
        logic [15:0] lds;
    } exp_t;

    exp_t sbq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    logic        vm  [NV];
    logic        vd  [NV];
    logic        ven [NV];
    logic        vdl [NV];
    logic        vrl [NV];
    int          vph [NV];
    bit          vcc [NV];
    logic [15:0] vce [NV];
    logic [15:0] vcl [NV];
    logic [31:0] vcp [NV];
    logic [31:0] tpc;
    int          tnum;

    // {runahead_mode, stall_release, checkpoint_save, checkpoint_restore, pipeline_flush, redirect_valid}
    function automatic logic [5:0] flags_of(input int p);
        case (p)
            P_E:     return 6'b101000;
            P_R:     return 6'b110000;
            P_X:     return 6'b100111;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic clear_vec();
        for (int i = 0; i < NV; i++) begin
            vm[i] = 1'b0; vd[i] = 1'b0; ven[i] = 1'b1; vdl[i] = 1'b0; vrl[i] = 1'b0;
            vph[i] = P_N; vcc[i] = 1'b0; vce[i] = '0; vcl[i] = '0; vcp[i] = '0;
        end
    endtask

    task automatic set_ph(input int lo, input int hi, input int p);
        for (int i = lo; i <= hi; i++) vph[i] = p;
    endtask

    task automatic hold_miss(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) vm[i] = 1'b1;
    endtask

    task automatic set_cnt(input int t, input logic [15:0] ent, input logic [15:0] lds,
                           input logic [31:0] pc);
        vcc[t] = 1'b1; vce[t] = ent; vcl[t] = lds; vcp[t] = pc;
    endtask

    task automatic drive(input logic m, input logic d, input logic en, input logic dl);
        bus_a.mem_load_miss = m;  bus_b.mem_load_miss = m;
        bus_a.mem_miss_done = d;  bus_b.mem_miss_done = d;
        bus_a.ra_enable     = en; bus_b.ra_enable     = en;
        bus_a.dec_load      = dl; bus_b.dec_load      = dl;
        bus_a.mem_load_pc   = tpc; bus_b.mem_load_pc  = tpc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run(input bit use_b, input int n);
        exp_t e;
        for (int t = 0; t < n; t++) begin
            drive(vm[t], vd[t], ven[t], vdl[t]);
            rst_n   = !vrl[t];
            e.test  = tnum;
            e.cyc   = t;
            e.use_b = use_b;
            e.flags = flags_of(vph[t]);
            e.chk_pc  = (vph[t] == P_X) || vcc[t];
            e.pc      = vcc[t] ? vcp[t] : tpc;
            e.chk_cnt = vcc[t];
            e.ent     = vce[t];
            e.lds     = vcl[t];
            sbq.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int tst, input int cyc,
                         input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL test%0d cycle%0d %s: got %h expected %h", tst, cyc, name, act, req);
    endtask

    initial begin : monitor
        exp_t        m;
        logic [5:0]  af;
        logic [31:0] apc;
        logic [15:0] aent, alds;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                m = sbq.pop_front();
                if (m.use_b) begin
                    af   = {bus_b.runahead_mode, bus_b.stall_release, bus_b.checkpoint_save,
                            bus_b.checkpoint_restore, bus_b.pipeline_flush, bus_b.redirect_valid};
                    apc  = bus_b.redirect_pc;
                    aent = bus_b.ra_entries;
                    alds = bus_b.ra_loads;
                end else begin
                    af   = {bus_a.runahead_mode, bus_a.stall_release, bus_a.checkpoint_save,
                            bus_a.checkpoint_restore, bus_a.pipeline_flush, bus_a.redirect_valid};
                    apc  = bus_a.redirect_pc;
                    aent = bus_a.ra_entries;
                    alds = bus_a.ra_loads;
                end
                check("flags", m.test, m.cyc, 32'(af), 32'(m.flags));
                if (m.chk_pc)  check("redirect_pc", m.test, m.cyc, apc, m.pc);
                if (m.chk_cnt) begin
                    check("ra_entries", m.test, m.cyc, 32'(aent), 32'(m.ent));
                    check("ra_loads",   m.test, m.cyc, 32'(alds), 32'(m.lds));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        tpc = '0;
        // 1: basic episode, miss at 10, done at 30
        tnum = 1; clear_vec(); tpc = 32'h0040_0100;
        hold_miss(10, 30); vd[30] = 1'b1;
        set_ph(11, 11, P_E); set_ph(12, 30, P_R); set_ph(31, 31, P_X);
        set_cnt(35, 16'd1, 16'd0, 32'h0040_0100);
        do_reset(); run(1'b0, 36);

        // 2: timeout with MAX_RA_CYCLES=8, miss held until done at 40
        tnum = 2; clear_vec(); tpc = 32'h0040_0200;
        hold_miss(5, 40); vd[40] = 1'b1;
        set_ph(6, 6, P_E); set_ph(7, 14, P_R); set_ph(15, 15, P_X); set_ph(16, 40, P_W);
        set_cnt(44, 16'd1, 16'd0, 32'h0040_0200);
        do_reset(); run(1'b1, 45);

        // 3: miss+done together gives no entry; done during ENTER returns to NORMAL
        tnum = 3; clear_vec(); tpc = 32'h0040_0400;
        vm[3] = 1'b1; vd[3] = 1'b1;
        hold_miss(8, 9); vd[9] = 1'b1;
        set_cnt(6, 16'd0, 16'd0, 32'h0000_0000);
        set_ph(9, 9, P_E); set_ph(10, 10, P_R); set_ph(11, 11, P_X);
        set_cnt(14, 16'd1, 16'd0, 32'h0040_0400);
        do_reset(); run(1'b1, 15);

        // 4: load counting, two loads in NORMAL, three in RUNAHEAD
        tnum = 4; clear_vec(); tpc = 32'h0040_0500;
        vdl[2] = 1'b1; vdl[4] = 1'b1; vdl[10] = 1'b1; vdl[12] = 1'b1; vdl[15] = 1'b1;
        hold_miss(6, 20); vd[20] = 1'b1;
        set_ph(7, 7, P_E); set_ph(8, 20, P_R); set_ph(21, 21, P_X);
        set_cnt(25, 16'd1, 16'd3, 32'h0040_0500);
        do_reset(); run(1'b0, 26);

        // 5: ra_enable dropped mid-RUNAHEAD, no done until 40
        tnum = 5; clear_vec(); tpc = 32'h0040_0300;
        hold_miss(4, 40); vd[40] = 1'b1;
        for (int i = 10; i < NV; i++) ven[i] = 1'b0;
        set_ph(5, 5, P_E); set_ph(6, 10, P_R); set_ph(11, 11, P_X); set_ph(12, 40, P_W);
        set_cnt(43, 16'd1, 16'd0, 32'h0040_0300);
        do_reset(); run(1'b0, 44);

        // 6: asynchronous reset during RUNAHEAD clears everything without a restore
        tnum = 6; clear_vec(); tpc = 32'h0040_0600;
        hold_miss(3, 10); vrl[8] = 1'b1; vrl[9] = 1'b1; vrl[10] = 1'b1;
        set_ph(4, 4, P_E); set_ph(5, 7, P_R);
        set_cnt(7, 16'd1, 16'd0, 32'h0040_0600);
        set_cnt(8, 16'd0, 16'd0, 32'h0000_0000);
        set_cnt(14, 16'd0, 16'd0, 32'h0000_0000);
        do_reset(); run(1'b0, 15);

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
        if (sbq.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending entries expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
